coriolis_ker0_obuf: RTL and testbench
=====================================

// Module: coriolis_ker0_obuf
// PURPOSE
//  Credit-style output buffer directly downstream of the ker0 FP-divide leaf node.
//  Absorbs the up to LAT+1 results still in flight in the upstream pipeline after
//  back-pressure, so no result is lost when the sink stalls.
//  Also counts FloPoCo exception results (non-normal exception field) for debug.
//  Sits between the ker0 leaf output and the next kernel or stream sink.
// PARAMETERS
//  STREAMW  34  data width: 2-bit FloPoCo exception field + 32-bit float
//  DEPTH    32  FIFO entries; must satisfy DEPTH >= LAT+2
//  LAT      13  upstream leaf pipeline latency in cycles
//  CNTW     16  width of exception counter
// PORTS
//  clk      in   1        clock, all state on rising edge
//  rst      in   1        asynchronous reset, active-low
//  ivalid   in   1        upstream result valid (upstream ovalid)
//  in1      in   STREAMW  upstream result data (upstream out1)
//  iready   out  1        to upstream oready; credit available
//  ovalid   out  1        buffered result valid to sink
//  out1     out  STREAMW  buffered result data, first-word-fall-through
//  oready   in   1        sink ready
//  exc_cnt  out  CNTW     results accepted with in1[STREAMW-1:STREAMW-2] != 2'b01
//  ovf      out  1        sticky: write attempted while full and no read
//  count    out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//  Reset (rst=0, async): wr_ptr=rd_ptr=count=0, exc_cnt=0, ovf=0; ovalid=0 immediately.
//  During reset iready=0. Memory contents are not reset. Deassertion is synchronised
//  internally to clk.
//  Reset mid-operation discards all buffered data.
//  Write:
//   - Accepted every cycle with ivalid=1 and (count<DEPTH or read this cycle).
//   - ivalid is never qualified by iready; upstream drains in-flight data after stall.
//  Write while full without a read: data dropped, ovf<=1 (sticky until reset).
//   Pointers and count are unchanged.
//  Read: ovalid = (count!=0); out1 = mem[rd_ptr]; a pop occurs when ovalid & oready.
//  Credit: iready = (count <= DEPTH-LAT-2), driven from the registered count only.
//   No combinational path from oready to iready.
//  Latency: a write into an empty buffer gives ovalid=1 on the next cycle.
//   There is no bypass in the same cycle.
//  Simultaneous push and pop: count unchanged; legal at count==DEPTH and count==1.
//   A pop at count==0 is impossible (ovalid=0).
//  Pointers wrap from DEPTH-1 to 0 explicitly (DEPTH need not be a power of 2).
//  exc_cnt increments once per accepted write whose exception field != 2'b01.
//   Saturates at all-ones; dropped writes are not counted.
//  count register: +1 on push only, -1 on pop only, else hold.
// TESTING
//  T1 reset: rst=0 mid-burst with count=5.
//   -> same cycle ovalid=0; after release count=0, exc_cnt=0, ovf=0, iready=1.
//  T2 ordering: push 40 values 0x1_3F800000+i with oready=1.
//   -> out1 sequence identical and in order; 1-cycle latency; count stays <=1.
//  T3 stall: oready=0 while writes continue.
//   -> iready falls when count reaches 18 (DEPTH-LAT-1).
//   -> 14 further in-flight writes accepted, count=32, ovf=0.
//  T4 full edge: count=32, ivalid=1 & oready=1 in the same cycle -> count stays 32, ovf=0.
//   Next cycle ivalid=1 & oready=0 -> ovf=1, data dropped.
//  T5 wrap: 100 push/pop cycles at count ~ DEPTH-1.
//   -> pointers wrap past 31 with no data corruption.
//  T6 exceptions: push 3 words with field 2'b11 and 2 with 2'b01 -> exc_cnt=3.
//   Force exc_cnt to all-ones, push one more field 2'b10 -> remains all-ones.

Source files
------------

// File: rtl/coriolis_ker0_obuf_if.sv
// Port bundle of the ker0 output buffer: upstream result stream, sink handshake and debug status.
// The buffer connects through the slave modport and its driver through the master modport.
interface coriolis_ker0_obuf_if #(
  parameter int STREAMW = 34,
  parameter int DEPTH   = 32,
  parameter int CNTW    = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               ivalid;
  logic [STREAMW-1:0] in1;
  logic               iready;
  logic               ovalid;
  logic [STREAMW-1:0] out1;
  logic               oready;
  logic [CNTW-1:0]    exc_cnt;
  logic               ovf;
  logic [CW-1:0]      count;

  modport slave (
    input  ivalid, in1, oready,
    output iready, ovalid, out1, exc_cnt, ovf, count
  );

  modport master (
    output ivalid, in1, oready,
    input  iready, ovalid, out1, exc_cnt, ovf, count
  );
endinterface

// File: rtl/coriolis_ker0_obuf.sv
// Credit-style FWFT output buffer behind the ker0 FP-divide leaf; absorbs the leaf's in-flight
// results after back-pressure and counts FloPoCo exception results for debug.
module coriolis_ker0_obuf #(
  parameter int STREAMW = 34,
  parameter int DEPTH   = 32,
  parameter int LAT     = 13,
  parameter int CNTW    = 16
) (
  input logic                 clk,
  input logic                 rst,
  coriolis_ker0_obuf_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0]   CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]   FULL_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0]   CREDIT_LVL = CW'(DEPTH - LAT - 2);
  localparam logic [PW-1:0]   PTR_ZERO   = PW'(0);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
  localparam logic [PW-1:0]   LAST_IDX   = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] EXC_ZERO   = CNTW'(0);
  localparam logic [CNTW-1:0] EXC_ONE    = CNTW'(1);
  localparam logic [CNTW-1:0] EXC_MAX    = {CNTW{1'b1}};
  localparam logic [1:0]      EXC_NORMAL = 2'b01;

  logic [1:0]         rst_sync_r;
  logic               rst_n_s;
  logic [STREAMW-1:0] mem_r [DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_nxt_s;
  logic [CNTW-1:0]    exc_cnt_r;
  logic               ovf_r;
  logic               iready_r;
  logic               ovalid_r;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               drop_s;
  logic               exc_s;

  // Reset asserts asynchronously and releases two clk edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Handshake decode; ovalid_r always mirrors count_r != 0, so a pop never hits an empty buffer.
  always_comb begin
    pop_s  = ovalid_r & bus.oready;
    full_s = (count_r == FULL_LVL);
    push_s = bus.ivalid & (~full_s | pop_s);
    drop_s = bus.ivalid & full_s & ~pop_s;
    exc_s  = (bus.in1[STREAMW-1:STREAMW-2] != EXC_NORMAL);
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage is deliberately left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.in1;
    end
  end

  // Occupancy, pointers, credit and status. iready/ovalid are registered from the next
  // occupancy, so they equal a function of count_r and carry no path from oready.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      ovalid_r  <= 1'b0;
      iready_r  <= 1'b0;
      ovf_r     <= 1'b0;
      exc_cnt_r <= EXC_ZERO;
    end else begin
      count_r  <= count_nxt_s;
      ovalid_r <= (count_nxt_s != CNT_ZERO);
      iready_r <= (count_nxt_s <= CREDIT_LVL);
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_IDX) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_IDX) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
      if (push_s && exc_s && (exc_cnt_r != EXC_MAX)) begin
        exc_cnt_r <= exc_cnt_r + EXC_ONE;
      end
    end
  end

  assign bus.iready  = iready_r;
  assign bus.ovalid  = ovalid_r;
  assign bus.out1    = mem_r[rd_ptr_r];
  assign bus.exc_cnt = exc_cnt_r;
  assign bus.ovf     = ovf_r;
  assign bus.count   = count_r;
endmodule

// File: tb/tb_coriolis_ker0_obuf.sv
// Directed self-checking bench for coriolis_ker0_obuf: reset, ordering, credit stall,
// full-edge drop, pointer wrap and exception counting (narrow CNTW to reach saturation).
module tb_coriolis_ker0_obuf;
  localparam int STREAMW = 34;
  localparam int DEPTH   = 32;
  localparam int LAT     = 13;
  localparam int CNTW    = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [STREAMW-1:0] exp_q [$];

  coriolis_ker0_obuf_if #(.STREAMW(STREAMW), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  coriolis_ker0_obuf #(.STREAMW(STREAMW), .DEPTH(DEPTH), .LAT(LAT), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ivalid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushes;
    rst        = 1'b0;
    bus.ivalid = 1'b0;
    bus.in1    = 34'h0_00000000;
    bus.oready = 1'b0;
    repeat (2) tick();
    chk("rst_ovalid", bus.ovalid, 64'd0);
    chk("rst_iready", bus.iready, 64'd0);
    chk("rst_count", bus.count, 64'd0);
    rst = 1'b1;
    repeat (4) tick();
    chk("rel_iready", bus.iready, 64'd1);

    // T1: reset in the middle of a burst with 5 entries held
    bus.ivalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in1 = 34'h1_00000000 + 34'(i);
      tick();
    end
    chk("t1_count", bus.count, 64'd5);
    chk("t1_ovalid", bus.ovalid, 64'd1);
    rst = 1'b0;
    #1;
    chk("t1_async_ovalid", bus.ovalid, 64'd0);
    chk("t1_async_count", bus.count, 64'd0);
    chk("t1_async_iready", bus.iready, 64'd0);
    bus.ivalid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("t1_count_after", bus.count, 64'd0);
    chk("t1_exc_after", bus.exc_cnt, 64'd0);
    chk("t1_ovf_after", bus.ovf, 64'd0);
    chk("t1_iready_after", bus.iready, 64'd1);
    chk("t1_ovalid_after", bus.ovalid, 64'd0);

    // T2: streaming with sink always ready, one-cycle latency
    bus.oready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.ivalid = 1'b1;
      bus.in1    = 34'h1_3F800000 + 34'(i);
      if (i == 0) chk("t2_no_bypass", bus.ovalid, 64'd0);
      tick();
      chk("t2_ovalid", bus.ovalid, 64'd1);
      chk("t2_out1", bus.out1, 64'(34'h1_3F800000 + 34'(i)));
      chk("t2_count", bus.count, 64'd1);
    end
    bus.ivalid = 1'b0;
    tick();
    chk("t2_drain_ovalid", bus.ovalid, 64'd0);
    chk("t2_drain_count", bus.count, 64'd0);

    // T3: sink stalls; credit drops at 18, leaf still delivers LAT+1 results
    bus.oready = 1'b0;
    bus.ivalid = 1'b1;
    pushes = 0;
    exp_q.delete();
    while (bus.iready && pushes < 40) begin
      bus.in1 = 34'h1_40000000 + 34'(pushes);
      exp_q.push_back(bus.in1);
      tick();
      pushes++;
    end
    chk("t3_stall_pushes", 64'(pushes), 64'd18);
    chk("t3_stall_count", bus.count, 64'd18);
    for (int i = 0; i < LAT + 1; i++) begin
      bus.in1 = 34'h1_50000000 + 34'(i);
      exp_q.push_back(bus.in1);
      tick();
    end
    chk("t3_full_count", bus.count, 64'd32);
    chk("t3_full_ovf", bus.ovf, 64'd0);
    chk("t3_full_iready", bus.iready, 64'd0);

    // T4: push+pop at full is legal; push at full without pop is dropped
    bus.in1    = 34'h1_60000000;
    bus.oready = 1'b1;
    tick();
    exp_q.delete(0);
    exp_q.push_back(34'h1_60000000);
    chk("t4_pushpop_count", bus.count, 64'd32);
    chk("t4_pushpop_ovf", bus.ovf, 64'd0);
    bus.in1    = 34'h1_70000000;
    bus.oready = 1'b0;
    tick();
    chk("t4_drop_ovf", bus.ovf, 64'd1);
    chk("t4_drop_count", bus.count, 64'd32);
    bus.ivalid = 1'b0;
    bus.oready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_drain_out1", bus.out1, 64'(exp_q[i]));
      tick();
    end
    chk("t4_empty_count", bus.count, 64'd0);
    chk("t4_empty_ovalid", bus.ovalid, 64'd0);
    chk("t4_ovf_sticky", bus.ovf, 64'd1);
    do_reset();
    chk("t4_ovf_cleared", bus.ovf, 64'd0);
    exp_q.delete();

    // T5: sustained push/pop near full so both pointers wrap repeatedly
    bus.oready = 1'b0;
    bus.ivalid = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      bus.in1 = 34'h1_80000000 + 34'(i);
      exp_q.push_back(bus.in1);
      tick();
    end
    chk("t5_fill_count", bus.count, 64'd31);
    bus.oready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in1 = 34'h1_90000000 + 34'(i);
      chk("t5_out1", bus.out1, 64'(exp_q[0]));
      tick();
      exp_q.delete(0);
      exp_q.push_back(bus.in1);
      chk("t5_count", bus.count, 64'd31);
    end
    bus.ivalid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      chk("t5_drain_out1", bus.out1, 64'(exp_q[i]));
      tick();
    end
    chk("t5_empty_count", bus.count, 64'd0);
    chk("t5_ovf", bus.ovf, 64'd0);
    exp_q.delete();

    // T6: exception counting, dropped writes ignored, saturation at all-ones
    bus.oready = 1'b1;
    bus.ivalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in1 = {2'b11, 32'h7FC00000};
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      bus.in1 = {2'b01, 32'h40400000};
      tick();
    end
    bus.ivalid = 1'b0;
    tick();
    chk("t6_exc3", bus.exc_cnt, 64'd3);
    bus.oready = 1'b0;
    bus.ivalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in1 = {2'b01, 32'h3F800000};
      tick();
    end
    bus.in1 = {2'b11, 32'h7F800000};
    tick();
    chk("t6_drop_exc", bus.exc_cnt, 64'd3);
    chk("t6_drop_ovf", bus.ovf, 64'd1);
    chk("t6_drop_count", bus.count, 64'd32);
    bus.ivalid = 1'b0;
    bus.oready = 1'b1;
    repeat (DEPTH) tick();
    chk("t6_drained", bus.count, 64'd0);
    bus.ivalid = 1'b1;
    bus.in1    = {2'b10, 32'h00000000};
    repeat (11) tick();
    chk("t6_exc14", bus.exc_cnt, 64'd14);
    tick();
    chk("t6_exc15", bus.exc_cnt, 64'd15);
    tick();
    chk("t6_sat", bus.exc_cnt, 64'd15);
    bus.ivalid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
